// File: rtl/int_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : int_alu_sequencer
//  Description : Execute-side sequencer in front of the integer ALU. Moves
//                opcode, src1 and src2 onto the shared execute bus with
//                falling-edge strobes, pulses compute and read, then returns
//                the ALU result together with the dest field.
//  Revision    : 1.0  initial release
// ============================================================================
module int_alu_sequencer #(
    parameter int ALU_SEL = 4,
    parameter int DATA_W  = 256
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] srcA_data,
    input  logic [DATA_W-1:0] srcB_data,
    input  logic [DATA_W-1:0] IntAluDataOut,
    output logic [DATA_W-1:0] ExecDataOut,
    output logic [15:0]       address,
    output logic              opcodeonBus,
    output logic              src1onBus,
    output logic              src2onBus,
    output logic              destonBus,
    output logic              nWrite,
    output logic              nRead,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [7:0]        dest_out
);

    localparam logic [15:0] ALU_ADDR = {4'(ALU_SEL), 12'h000};

    // Each *_SU state presents data/address; the matching *_PL state holds
    // them while the strobe is low. REJECT reports an illegal instruction one
    // edge after acceptance without ever touching the bus.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        OP_SU  = 4'd1,
        OP_PL  = 4'd2,
        S1_SU  = 4'd3,
        S1_PL  = 4'd4,
        S2_SU  = 4'd5,
        S2_PL  = 4'd6,
        EXEC   = 4'd7,
        RD     = 4'd8,
        CAP    = 4'd9,
        REJECT = 4'd10
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        dest_q, dest_nxt;
    logic [DATA_W-1:0] opa_q, opa_nxt;
    logic [DATA_W-1:0] opb_q, opb_nxt;

    logic [DATA_W-1:0] data_nxt, result_nxt;
    logic [15:0]       addr_nxt;
    logic              op_stb_nxt, s1_stb_nxt, s2_stb_nxt;
    logic              nwrite_nxt, nread_nxt;
    logic              busy_nxt, done_nxt, err_nxt;
    logic [7:0]        dest_out_nxt;

    logic [7:0]        opcode_in;
    logic              opcode_ok;
    logic              div_zero;

    // The ALU result register is never targeted, so the dest strobe stays idle.
    assign destonBus = 1'b1;

    // Classify the incoming instruction while it is still on the inputs.
    always_comb begin
        opcode_in = instr[31:24];
        opcode_ok = (opcode_in >= 8'h10) && (opcode_in <= 8'h13);
        div_zero  = (opcode_in == 8'h13) && (srcB_data == '0);
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt    = state;
        dest_nxt     = dest_q;
        opa_nxt      = opa_q;
        opb_nxt      = opb_q;
        data_nxt     = '0;
        addr_nxt     = ALU_ADDR;
        op_stb_nxt   = 1'b1;
        s1_stb_nxt   = 1'b1;
        s2_stb_nxt   = 1'b1;
        nwrite_nxt   = 1'b1;
        nread_nxt    = 1'b1;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        err_nxt      = err;
        result_nxt   = result;
        dest_out_nxt = dest_out;

        case (state)
            IDLE: begin
                addr_nxt = '0;
                if (start) begin
                    dest_nxt = instr[23:16];
                    opa_nxt  = srcA_data;
                    opb_nxt  = srcB_data;
                    if (!opcode_ok || div_zero) begin
                        state_nxt = REJECT;
                    end else begin
                        state_nxt = OP_SU;
                        busy_nxt  = 1'b1;
                        addr_nxt  = ALU_ADDR;
                        data_nxt  = {{(DATA_W-8){1'b0}}, opcode_in};
                    end
                end
            end
            OP_SU: begin
                state_nxt  = OP_PL;
                data_nxt   = ExecDataOut;
                op_stb_nxt = 1'b0;
            end
            OP_PL: begin
                state_nxt = S1_SU;
                data_nxt  = opa_q;
            end
            S1_SU: begin
                state_nxt  = S1_PL;
                data_nxt   = ExecDataOut;
                s1_stb_nxt = 1'b0;
            end
            S1_PL: begin
                state_nxt = S2_SU;
                data_nxt  = opb_q;
            end
            S2_SU: begin
                state_nxt  = S2_PL;
                data_nxt   = ExecDataOut;
                s2_stb_nxt = 1'b0;
            end
            S2_PL: begin
                state_nxt  = EXEC;
                nwrite_nxt = 1'b0;
            end
            EXEC: begin
                state_nxt = RD;
                nread_nxt = 1'b0;
            end
            RD: begin
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt    = IDLE;
                addr_nxt     = '0;
                result_nxt   = IntAluDataOut;
                dest_out_nxt = dest_q;
                err_nxt      = 1'b0;
                done_nxt     = 1'b1;
                busy_nxt     = 1'b0;
            end
            REJECT: begin
                state_nxt    = IDLE;
                addr_nxt     = '0;
                result_nxt   = '0;
                dest_out_nxt = dest_q;
                err_nxt      = 1'b1;
                done_nxt     = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, operand latches and registered outputs; reset abandons any op.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            dest_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ExecDataOut <= '0;
            address     <= '0;
            opcodeonBus <= 1'b1;
            src1onBus   <= 1'b1;
            src2onBus   <= 1'b1;
            nWrite      <= 1'b1;
            nRead       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            result      <= '0;
            dest_out    <= '0;
        end else begin
            state       <= state_nxt;
            dest_q      <= dest_nxt;
            opa_q       <= opa_nxt;
            opb_q       <= opb_nxt;
            ExecDataOut <= data_nxt;
            address     <= addr_nxt;
            opcodeonBus <= op_stb_nxt;
            src1onBus   <= s1_stb_nxt;
            src2onBus   <= s2_stb_nxt;
            nWrite      <= nwrite_nxt;
            nRead       <= nread_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            result      <= result_nxt;
            dest_out    <= dest_out_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_alu_sequencer
//  Description : Bench for int_alu_sequencer with a behavioural integer ALU
//                attached to the execute bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_alu_sequencer;

    localparam int ALU_SEL = 4;
    localparam int DATA_W  = 256;

    logic              Clk = 1'b0;
    logic              nReset;
    logic              start;
    logic [31:0]       instr;
    logic [DATA_W-1:0] srcA_data, srcB_data, IntAluDataOut;
    logic [DATA_W-1:0] ExecDataOut, result;
    logic [15:0]       address;
    logic              opcodeonBus, src1onBus, src2onBus, destonBus;
    logic              nWrite, nRead, busy, done, err;
    logic [7:0]        dest_out;

    int checks = 0;
    int errors = 0;

    int         done_cnt    = 0;
    int         addr_nz_cnt = 0;
    int         overlap_cnt = 0;
    int         stab_cnt    = 0;
    int         dest_cnt    = 0;
    logic [3:0] ev_log[$];
    int         ev_base     = 0;
    int         addr_base   = 0;

    int_alu_sequencer #(.ALU_SEL(ALU_SEL), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .nReset(nReset), .start(start), .instr(instr),
        .srcA_data(srcA_data), .srcB_data(srcB_data), .IntAluDataOut(IntAluDataOut),
        .ExecDataOut(ExecDataOut), .address(address),
        .opcodeonBus(opcodeonBus), .src1onBus(src1onBus), .src2onBus(src2onBus),
        .destonBus(destonBus), .nWrite(nWrite), .nRead(nRead),
        .busy(busy), .done(done), .err(err), .result(result), .dest_out(dest_out)
    );

    always #5 Clk = ~Clk;

    // Reference arithmetic: what the ALU should return for an instruction.
    function automatic logic [255:0] ref_calc(input logic [7:0] op, input logic [255:0] a, input logic [255:0] b);
        case (op)
            8'h10:   return a + b;
            8'h11:   return a - b;
            8'h12:   return a * b;
            8'h13:   return (b == '0) ? '0 : a / b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    // Behavioural integer ALU: captures bus values on strobe falling edges.
    logic [7:0]   alu_op  = '0;
    logic [255:0] alu_a   = '0, alu_b = '0, alu_res = '0, alu_out = '0;
    always @(negedge opcodeonBus) if (address[15:12] == 4'(ALU_SEL)) alu_op <= ExecDataOut[7:0];
    always @(negedge src1onBus)   if (address[15:12] == 4'(ALU_SEL)) alu_a  <= ExecDataOut;
    always @(negedge src2onBus)   if (address[15:12] == 4'(ALU_SEL)) alu_b  <= ExecDataOut;
    always @(negedge nWrite or negedge nRead) begin
        if (!nRead) alu_out <= alu_res;
        else if (!nWrite) begin
            alu_res <= ref_calc(alu_op, alu_a, alu_b);
            alu_out <= rand256();
        end
    end
    assign IntAluDataOut = alu_out;

    // Bus monitor: logs strobe events and protocol violations every cycle.
    logic [255:0] prev_data = '0;
    logic [15:0]  prev_addr = '0;
    initial forever begin
        int nlow;
        @(negedge Clk);
        nlow = 0;
        if (!opcodeonBus) begin ev_log.push_back(4'h1); nlow++; end
        if (!src1onBus)   begin ev_log.push_back(4'h2); nlow++; end
        if (!src2onBus)   begin ev_log.push_back(4'h3); nlow++; end
        if (!nWrite)      begin ev_log.push_back(4'h4); nlow++; end
        if (!nRead)       begin ev_log.push_back(4'h5); nlow++; end
        if (nlow > 1) overlap_cnt++;
        if (!destonBus) dest_cnt++;
        if ((!opcodeonBus || !src1onBus || !src2onBus) &&
            (ExecDataOut !== prev_data || address !== prev_addr)) stab_cnt++;
        if (address != 16'h0) addr_nz_cnt++;
        if (done) done_cnt++;
        prev_data = ExecDataOut;
        prev_addr = address;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_strobes"}, 256'({opcodeonBus, src1onBus, src2onBus, destonBus, nWrite, nRead}), 256'(6'h3F));
        check({tag, "_data"},    ExecDataOut, '0);
        check({tag, "_addr"},    256'(address), '0);
        check({tag, "_flags"},   256'({busy, done, err}), '0);
        check({tag, "_result"},  result, '0);
        check({tag, "_dest"},    256'(dest_out), '0);
    endtask

    // Presents one instruction; returns just after the accepting edge.
    task automatic issue(input logic [7:0] op, input logic [7:0] dst, input logic [255:0] a, input logic [255:0] b);
        instr     = {op, dst, 8'($urandom()), 8'($urandom())};
        srcA_data = a;
        srcB_data = b;
        start     = 1'b1;
        ev_base   = ev_log.size();
        addr_base = addr_nz_cnt;
        @(posedge Clk);
        #1;
        start     = 1'b0;
        srcA_data = rand256();
        srcB_data = rand256();
        instr     = $urandom();
    endtask

    // Waits for done and checks everything about the completed instruction.
    task automatic finish_op(input logic [7:0] op, input logic [7:0] dst, input logic [255:0] a,
                             input logic [255:0] b, input int poke);
        int          cyc = 0;
        logic        legal;
        logic [31:0] seq = '0;
        legal = (op >= 8'h10) && (op <= 8'h13) && !(op == 8'h13 && b == '0);
        while (cyc < 20) begin
            tick();
            cyc++;
            start = (cyc == poke);
            if (cyc == 1) begin
                check("busy_after_accept", 256'(busy), 256'(legal));
                check("done_not_early", 256'(done), '0);
            end
            if (done) break;
        end
        start = 1'b0;
        check("latency", 256'(cyc), legal ? 256'd10 : 256'd2);
        check("result", result, legal ? ref_calc(op, a, b) : '0);
        check("err", 256'(err), 256'(!legal));
        check("dest_out", 256'(dest_out), 256'(dst));
        check("busy_at_done", 256'(busy), '0);
        for (int i = ev_base; i < ev_log.size(); i++) seq = {seq[27:0], ev_log[i]};
        check("strobe_seq", 256'(seq), legal ? 256'h12345 : '0);
        check("addr_cycles", 256'(addr_nz_cnt - addr_base), legal ? 256'd9 : '0);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [7:0] dst, input logic [255:0] a, input logic [255:0] b);
        issue(op, dst, a, b);
        finish_op(op, dst, a, b, 0);
    endtask

    initial begin
        int d0;
        nReset    = 1'b0;
        start     = 1'b0;
        instr     = '0;
        srcA_data = '0;
        srcB_data = '0;
        repeat (3) tick();
        check_reset("reset");
        nReset = 1'b1;
        repeat (2) tick();

        // Directed cases; each call issues on the done cycle of the last.
        run_op(8'h10, 8'h21, 256'd5, 256'd7);
        run_op(8'h11, 8'h22, 256'd0, 256'd1);
        check("sub_all_ones", result, {256{1'b1}});
        run_op(8'h12, 8'h23, 256'd3, 256'd4);
        run_op(8'h13, 8'h24, 256'd100, 256'd7);
        check("div_14", result, 256'd14);
        run_op(8'h13, 8'h25, 256'd100, 256'd0);
        run_op(8'hFF, 8'h26, 256'd1, 256'd2);
        run_op(8'h10, 8'h27, 256'd8, 256'd9);

        // A start pulse during S1_PL must not launch a second instruction.
        issue(8'h10, 8'h31, 256'd40, 256'd2);
        finish_op(8'h10, 8'h31, 256'd40, 256'd2, 4);
        d0 = done_cnt;
        repeat (15) tick();
        check("single_done", 256'(done_cnt - d0), '0);
        check("idle_after_ignored_start", 256'(busy), '0);

        // Asynchronous reset while the ALU compute strobe is low.
        issue(8'h10, 8'h41, 256'd9, 256'd9);
        repeat (7) tick();
        check("exec_nwrite_low", 256'(nWrite), '0);
        #1 nReset = 1'b0;
        #1;
        check_reset("async_reset");
        d0 = done_cnt;
        repeat (3) tick();
        nReset = 1'b1;
        repeat (15) tick();
        check("no_done_after_reset", 256'(done_cnt - d0), '0);
        run_op(8'h10, 8'h42, 256'd1, 256'd1);
        check("add_1_1", result, 256'd2);

        // Randomised instruction stream, issued back-to-back.
        for (int n = 0; n < 24; n++) begin
            logic [7:0]   op;
            logic [255:0] a, b;
            int           sel = int'($urandom_range(0, 9));
            a = rand256();
            b = rand256();
            if (sel < 2)      op = 8'h10;
            else if (sel < 4) op = 8'h11;
            else if (sel < 6) op = 8'h12;
            else if (sel < 8) begin
                op = 8'h13;
                if (sel == 7) b = 256'($urandom_range(1, 255));
            end else if (sel == 8) begin
                op = 8'h13;
                b  = '0;
            end else op = 8'($urandom_range(8'h14, 8'hFF));
            run_op(op, 8'($urandom()), a, b);
        end

        repeat (3) tick();
        check("no_strobe_overlap", 256'(overlap_cnt), '0);
        check("bus_stable_under_strobe", 256'(stab_cnt), '0);
        check("dest_strobe_idle", 256'(dest_cnt), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
